// File: rtl/hsync_bus.sv
// hsync_bus: two-phase toggle req/ack handshake carrying a W-bit word from clki to clko.
// Optional source-side saturating overflow counter: define HSYNC_BUS_OVF_CNT_EN.
module hsync_bus #(
  parameter int unsigned W   = 8,
  parameter int unsigned LEN = 3
) (
  input  logic         rst,
  input  logic         clki,
  input  logic         clko,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [7:0]   ovf_cnt
);

  if (LEN < 2) begin : g_len_chk
    $error("hsync_bus: LEN must be >= 2, got %0d", LEN);
  end
  if (W < 1) begin : g_w_chk
    $error("hsync_bus: W must be >= 1, got %0d", W);
  end

  typedef enum logic {S_IDLE, S_BUSY} src_state_e;
  typedef enum logic {D_WAIT, D_HOLD} dst_state_e;

  // ---------------- source domain (clki) ----------------
  src_state_e     src_q, src_d;
  logic           req_t, req_d;
  logic [W-1:0]   data_q, data_d;
  logic [LEN-1:0] ack_s, ack_s_d;

  // ---------------- destination domain (clko) ----------------
  dst_state_e     dst_q, dst_d;
  logic           ack_t, ack_d;
  logic           out_valid_d;
  logic [W-1:0]   out_data_d;
  logic [LEN-1:0] req_s, req_s_d;

  assign ack_s_d[0] = ack_t;
  assign req_s_d[0] = req_t;
  for (genvar g = 1; g < LEN; g++) begin : g_sync
    assign ack_s_d[g] = ack_s[g-1];
    assign req_s_d[g] = req_s[g-1];
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      src_q  <= S_IDLE;
      req_t  <= 1'b0;
      data_q <= '0;
      ack_s  <= '0;
    end else begin
      src_q  <= src_d;
      req_t  <= req_d;
      data_q <= data_d;
      ack_s  <= ack_s_d;
    end
  end

  // The ack toggle catching up with req_t means the dest has consumed the word.
  always_comb begin
    src_d    = src_q;
    req_d    = req_t;
    data_d   = data_q;
    in_ready = 1'b0;
    case (src_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d = in_data;
          req_d  = ~req_t;
          src_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (ack_s[LEN-1] == req_t) src_d = S_IDLE;
      end
      default: src_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clko or posedge rst) begin
    if (rst) begin
      dst_q     <= D_WAIT;
      ack_t     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      req_s     <= '0;
    end else begin
      dst_q     <= dst_d;
      ack_t     <= ack_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      req_s     <= req_s_d;
    end
  end

  // data_q is captured without per-bit sync: it has been frozen since before req_t toggled.
  always_comb begin
    dst_d       = dst_q;
    ack_d       = ack_t;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    case (dst_q)
      D_WAIT: begin
        if (req_s[LEN-1] != ack_t) begin
          out_data_d  = data_q;
          out_valid_d = 1'b1;
          dst_d       = D_HOLD;
        end
      end
      D_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = ~ack_t;
          dst_d       = D_WAIT;
        end
      end
      default: dst_d = D_WAIT;
    endcase
  end

`ifdef HSYNC_BUS_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (in_valid && !in_ready && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_hsync_bus.sv
// tb_hsync_bus: randomized self-checking bench for hsync_bus, run at both clock ratios.
`timescale 1ns/10ps
module tb_hsync_bus;

  localparam int W   = 8;
  localparam int LEN = 3;
  localparam realtime SMP = 0.2;

  logic         rst;
  logic         clki = 1'b0;
  logic         clko = 1'b0;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [7:0]   ovf_cnt;

  int errors = 0;
  int checks = 0;

  realtime hi_i = 5.0;
  realtime hi_o = 13.5;
  bit      clk_run = 1'b1;

  hsync_bus #(.W(W), .LEN(LEN)) dut (
    .rst       (rst),
    .clki      (clki),
    .clko      (clko),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ovf_cnt   (ovf_cnt)
  );

  // Half periods 5.0 and 13.5 keep rising edges of the two clocks at least 0.5 ns apart.
  always begin
    wait (clk_run);
    #(hi_i);
    if (clk_run) clki = ~clki;
  end
  always begin
    wait (clk_run);
    #(hi_o);
    if (clk_run) clko = ~clko;
  end

  // Reference model: words taken by the handshake on each side, and the overflow rule.
  logic [W-1:0] acc_q[$];
  logic [W-1:0] rcv_q[$];
  int           ovf_model;
  bit           ov_seen;

  always @(posedge clki or posedge rst) begin
    if (rst) begin
      ovf_model <= 0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(in_data);
      if (in_valid && !in_ready && ovf_model < 255) ovf_model <= ovf_model + 1;
    end
  end

  always @(posedge clko) begin
    if (!rst) begin
      if (out_valid && out_ready) rcv_q.push_back(out_data);
      if (out_valid) ov_seen = 1'b1;
    end
  end

  function automatic int ovf_expect();
`ifdef HSYNC_BUS_OVF_CNT_EN
    return ovf_model;
`else
    return 0;
`endif
  endfunction

  task automatic ci();
    @(posedge clki);
    #(SMP);
  endtask

  task automatic co();
    @(posedge clko);
    #(SMP);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) co();
    repeat (3) ci();
    rst = 1'b0;
    ci();
  endtask

  // Offers d once the source is idle; returns at the accepting edge + SMP.
  task automatic send(input logic [W-1:0] d, output bit ok);
    int unsigned n;
    n = 0;
    ci();
    while (!in_ready && n < 300) begin
      ci();
      n++;
    end
    in_data  = d;
    in_valid = 1'b1;
    ci();
    in_valid = 1'b0;
    ok = (n < 300);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++;
    if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    int unsigned n;
    rcv_q.delete();
    out_ready = 1'b1;
    send(8'hA5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_send: source never idle (got 0 expected 1)"); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL single_busy: in_ready got %b expected 0", in_ready); end
    n = 0;
    do begin co(); n++; end while (!out_valid && n < 20);
    checks++;
    if (n != LEN + 1) begin errors++; $display("FAIL single_out_latency: got %0d clko edges expected %0d", n, LEN + 1); end
    checks++;
    if (out_data !== 8'hA5) begin errors++; $display("FAIL single_out_data: got %h expected a5", out_data); end
    co();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: out_valid got %b expected 0", out_valid); end
    n = 0;
    do begin ci(); n++; end while (!in_ready && n < 20);
    checks++;
    if (n != LEN + 1) begin errors++; $display("FAIL single_ready_latency: got %0d clki edges expected %0d", n, LEN + 1); end
    checks++;
    if (rcv_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d words expected 1", rcv_q.size()); end
    else if (rcv_q[0] !== 8'hA5) begin errors++; $display("FAIL single_word: got %h expected a5", rcv_q[0]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int unsigned n;
    rcv_q.delete();
    out_ready = 1'b0;
    send(8'h3C, ok);
    n = 0;
    while (!out_valid && n < 20) begin co(); n++; end
    checks++;
    if (!ok || out_valid !== 1'b1) begin errors++; $display("FAIL bp_arrive: out_valid got %b expected 1", out_valid); end
    for (int i = 0; i < 20; i++) begin
      co();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid/data/ready got %b/%h/%b expected 1/3c/0", i, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    co();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: out_valid got %b expected 0", out_valid); end
    n = 0;
    while (!in_ready && n < 20) begin ci(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: in_ready got %b expected 1", in_ready); end
    repeat (10) co();
    checks++;
    if (rcv_q.size() != 1 || rcv_q[0] !== 8'h3C) begin
      errors++;
      $display("FAIL bp_transfers: got %0d words expected exactly one 3c", rcv_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    bit          src_to;
    int unsigned cyc;
    int unsigned n;
    rcv_q.delete();
    acc_q.delete();
    src_to = 1'b0;
    cyc = 0;
    fork
      begin
        bit          rdy;
        int unsigned k;
        ci();
        for (int i = 0; i < 256; i++) begin
          if (!src_to) begin
            in_data  = i[7:0];
            in_valid = 1'b1;
            k = 0;
            do begin rdy = in_ready; ci(); k++; end while (!rdy && k < 500);
            if (!rdy) src_to = 1'b1;
          end
        end
        in_valid = 1'b0;
      end
      begin
        while (rcv_q.size() < 256 && cyc < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          co();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (src_to) begin errors++; $display("FAIL stream_source: accept timed out (got 1 expected 0)"); end
    checks++;
    if (rcv_q.size() != 256) begin errors++; $display("FAIL stream_count: got %0d words expected 256", rcv_q.size()); end
    checks++;
    if (acc_q.size() != 256) begin errors++; $display("FAIL stream_accepts: got %0d accepts expected 256", acc_q.size()); end
    for (int i = 0; i < 256; i++) begin
      if (i < rcv_q.size()) begin
        checks++;
        if (rcv_q[i] !== i[7:0]) begin errors++; $display("FAIL stream_word[%0d]: got %h expected %h", i, rcv_q[i], i[7:0]); end
      end
    end
    checks++;
    if (int'(ovf_cnt) != ovf_expect()) begin errors++; $display("FAIL stream_ovf: got %0d expected %0d", ovf_cnt, ovf_expect()); end
    n = 0;
    while (!in_ready && n < 30) begin ci(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_idle: in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_overflow();
    int unsigned n;
    do_reset();
    rcv_q.delete();
    out_ready = 1'b0;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (100) ci();
    checks++;
    if (int'(ovf_cnt) != ovf_expect()) begin errors++; $display("FAIL ovf_mid: got %0d expected %0d", ovf_cnt, ovf_expect()); end
    repeat (200) ci();
    checks++;
    if (int'(ovf_cnt) != ovf_expect()) begin errors++; $display("FAIL ovf_model: got %0d expected %0d", ovf_cnt, ovf_expect()); end
`ifdef HSYNC_BUS_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL ovf_saturate: got %0d expected 255", ovf_cnt); end
`else
    checks++;
    if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL ovf_disabled: got %0d expected 0", ovf_cnt); end
`endif
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
      errors++;
      $display("FAIL ovf_hold: ready/valid/data got %b/%b/%h expected 0/1/5a", in_ready, out_valid, out_data);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin ci(); n++; end
    repeat (5) co();
    checks++;
    if (rcv_q.size() != 1 || rcv_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL ovf_single_word: got %0d words expected exactly one 5a", rcv_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int unsigned n;
    rcv_q.delete();
    out_ready = 1'b1;
    send(8'h77, ok);
    checks++;
    if (!ok || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_busy: ready/valid got %b/%b expected 0/0", in_ready, out_valid);
    end
    rst = 1'b1;
    ov_seen = 1'b0;
    repeat (3) co();
    repeat (3) ci();
    rst = 1'b0;
    repeat (20) co();
    checks++;
    if (ov_seen || rcv_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_discard: out_valid seen %b words %0d expected 0 and 0", ov_seen, rcv_q.size());
    end
    checks++;
    if (in_ready !== 1'b1 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL rmid_state: ready/data got %b/%h expected 1/00", in_ready, out_data);
    end
    send(8'h11, ok);
    n = 0;
    while (rcv_q.size() == 0 && n < 30) begin co(); n++; end
    repeat (3) co();
    checks++;
    if (rcv_q.size() != 1 || rcv_q[0] !== 8'h11) begin
      errors++;
      $display("FAIL rmid_next: got %0d words expected exactly one 11", rcv_q.size());
    end
    n = 0;
    while (!in_ready && n < 30) begin ci(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: in_ready got %b expected 1", in_ready); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    ov_seen = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        rst = 1'b1;
        clk_run = 1'b0;
        #40;
        clki = 1'b0;
        clko = 1'b0;
        hi_i = 13.5;
        hi_o = 5.0;
        clk_run = 1'b1;
      end
      test_reset();
      test_single();
      test_backpressure();
      test_stream();
      test_overflow();
      test_reset_mid();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached (got timeout expected completion)");
    $fatal(1);
  end

endmodule
